// File: rtl/posit_div_pkg.sv
// Shared definitions for the sequential posit divider.
// Contents: FSM state encodings, NaR / maxpos pattern helpers, and the
// width of the signed scale registers.
package posit_div_pkg;

  // FSM state encodings
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] DIVIDE = 3'd2;
  localparam logic [2:0] ROUND  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // Scale register width: regime magnitude bits + exponent bits + sign + headroom
  function automatic int unsigned scale_width(input int unsigned n, input int unsigned es);
    return $clog2(n) + es + 2;
  endfunction

  // NaR pattern: 1 followed by n-1 zeros (right-aligned in 64 bits)
  function automatic logic [63:0] nar(input int unsigned n);
    return 64'(1) << (n - 1);
  endfunction

  // Largest positive posit: 0 followed by n-1 ones (right-aligned in 64 bits)
  function automatic logic [63:0] maxpos(input int unsigned n);
    return (64'(1) << (n - 1)) - 64'(1);
  endfunction

endpackage

// File: rtl/posit_div_round.sv
// Combinational posit packer for the divider quotient.
// Ports:
//   sign   - result sign
//   scale  - signed result scale (k*2^ES + e), already normalised
//   frac   - quotient fraction bits below the hidden bit
//   sticky - OR of any division remainder bits
//   res    - rounded (nearest, ties to even), saturated, packed posit
module posit_div_round
  import posit_div_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned ES = 2,
  parameter int unsigned SW = 9,
  parameter int unsigned FW = 31
) (
  input  logic                 sign,
  input  logic signed [SW-1:0] scale,
  input  logic [FW-1:0]        frac,
  input  logic                 sticky,
  output logic [N-1:0]         res
);

  localparam int unsigned TW = 1 + ES + FW + N;
  localparam logic [N-2:0] MAXP = (N-1)'(maxpos(N));
  localparam logic [N-2:0] MINP = (N-1)'(1);
  localparam logic signed [SW-1:0] KMAX = SW'(N - 2);

  logic signed [SW-1:0] k;
  logic [SW-1:0]        cnt;
  logic [TW-1:0]        tmp;
  logic [TW-1:0]        sh;
  logic [N-2:0]         body;
  logic [N-2:0]         mag;
  logic                 guard;
  logic                 rest;
  logic                 up;

  // Regime is produced by shifting {terminator, exp, frac} right and filling
  // with the regime bit; the ~(~x >> n) form fills with ones for k >= 0.
  always_comb begin
    k     = scale >>> ES;
    cnt   = k[SW-1] ? SW'(-k) : SW'(k + 1);
    tmp   = {k[SW-1], scale[ES-1:0], frac, N'(0)};
    sh    = k[SW-1] ? (tmp >> cnt) : ~((~tmp) >> cnt);
    body  = sh[TW-1 -: N-1];
    guard = sh[TW-N];
    rest  = (|sh[TW-N-1:0]) | sticky;
    up    = guard & (body[0] | rest);
    mag   = body + (N-1)'(up);
    // Out-of-range regimes saturate; magnitude never collapses to zero or NaR
    if (k >= KMAX) begin
      mag = MAXP;
    end else if (k < -KMAX) begin
      mag = MINP;
    end
    if (mag == '0) begin
      mag = MINP;
    end
    res = sign ? -{1'b0, mag} : {1'b0, mag};
  end

endmodule

// File: rtl/posit_divider_seq.sv
// Sequential posit divider: OUT = IN1 / IN2, one quotient bit per cycle by
// restoring division, valid/ready handshake on both sides.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - operand handshake (IN1 dividend, IN2 divisor)
//   out_valid / out_ready- result handshake (OUT quotient)
//   busy                 - high whenever the FSM is not in IDLE
module posit_divider_seq
  import posit_div_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned ES = 2,
  parameter int unsigned QW = N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] IN1,
  input  logic [N-1:0] IN2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] OUT,
  output logic         busy
);

  localparam int unsigned SW = scale_width(N, ES);
  localparam int unsigned F  = N - ES - 3;
  localparam int unsigned CW = $clog2(QW + 1);
  localparam logic [N-1:0] NAR = N'(nar(N));

  logic [2:0]           state, state_d;
  logic [N-1:0]         op1, op1_d, op2, op2_d;
  logic                 res_sign, res_sign_d;
  logic signed [SW-1:0] scale, scale_d;
  logic [F:0]           mant2, mant2_d;
  logic [F+1:0]         rem, rem_d;
  logic [QW-1:0]        quot, quot_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic                 in_ready_d, out_valid_d, busy_d;
  logic [N-1:0]         out_d;

  logic signed [SW-1:0] s1, s2, nscale;
  logic [F:0]           m1, m2;
  logic [QW-2:0]        nfrac;
  logic [N-1:0]         rnd;

  // Posit unpack: magnitude, regime run length, exponent, hidden-bit mantissa
  function automatic void unpack(input  logic [N-1:0]         x,
                                 output logic signed [SW-1:0] sc,
                                 output logic [F:0]           mant);
    logic [N-1:0] a;
    logic [N-2:0] body;
    logic [N-2:0] rest;
    logic         r;
    logic         run;
    int unsigned  m;
    int           k;
    a    = x[N-1] ? -x : x;
    body = a[N-2:0];
    r    = body[N-2];
    m    = 0;
    run  = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (body[i] == r)) m++;
      else run = 1'b0;
    end
    rest = body << (m + 1);
    k    = r ? int'(m) - 1 : -int'(m);
    sc   = SW'((k <<< ES) + int'(rest[N-2 -: ES]));
    mant = {1'b1, rest[N-2-ES -: F]};
  endfunction

  always_comb begin
    unpack(op1, s1, m1);
    unpack(op2, s2, m2);
  end

  // Quotient below 1.0 is renormalised before packing
  always_comb begin
    nfrac  = quot[QW-1] ? quot[QW-2:0] : {quot[QW-3:0], 1'b0};
    nscale = quot[QW-1] ? scale : scale - SW'(1);
  end

  posit_div_round #(
    .N (N),
    .ES(ES),
    .SW(SW),
    .FW(QW - 1)
  ) u_round (
    .sign  (res_sign),
    .scale (nscale),
    .frac  (nfrac),
    .sticky(|rem),
    .res   (rnd)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state;
    op1_d      = op1;
    op2_d      = op2;
    res_sign_d = res_sign;
    scale_d    = scale;
    mant2_d    = mant2;
    rem_d      = rem;
    quot_d     = quot;
    cnt_d      = cnt;
    out_d      = OUT;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          op1_d   = IN1;
          op2_d   = IN2;
          state_d = DECODE;
        end
      end
      DECODE: begin
        res_sign_d = op1[N-1] ^ op2[N-1];
        scale_d    = s1 - s2;
        mant2_d    = m2;
        rem_d      = {1'b0, m1};
        quot_d     = '0;
        cnt_d      = '0;
        if (op1 == NAR || op2 == NAR || op2 == '0) begin
          out_d   = NAR;
          state_d = DONE;
        end else if (op1 == '0) begin
          out_d   = '0;
          state_d = DONE;
        end else begin
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (rem >= {1'b0, mant2}) begin
          quot_d = {quot[QW-2:0], 1'b1};
          rem_d  = (rem - {1'b0, mant2}) << 1;
        end else begin
          quot_d = {quot[QW-2:0], 1'b0};
          rem_d  = rem << 1;
        end
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(QW - 1)) state_d = ROUND;
      end
      ROUND: begin
        out_d   = rnd;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op1       <= '0;
      op2       <= '0;
      res_sign  <= 1'b0;
      scale     <= '0;
      mant2     <= '0;
      rem       <= '0;
      quot      <= '0;
      cnt       <= '0;
      OUT       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      op1       <= op1_d;
      op2       <= op2_d;
      res_sign  <= res_sign_d;
      scale     <= scale_d;
      mant2     <= mant2_d;
      rem       <= rem_d;
      quot      <= quot_d;
      cnt       <= cnt_d;
      OUT       <= out_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_posit_divider_seq.sv
// Scoreboard bench for posit_divider_seq: the driver queues expected results
// and latencies, a negedge monitor compares each result as it appears.
module tb_posit_divider_seq;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] IN1;
  logic [N-1:0] IN2;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] OUT;
  logic         busy;

  always #5 clk = ~clk;

  posit_divider_seq #(.N(N), .ES(2), .QW(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .IN1      (IN1),
    .IN2      (IN2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .OUT      (OUT),
    .busy     (busy)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          hs_q[$];
  logic        ov_prev  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Monitor: handshake times and result checks, all sampled at negedge
  always @(negedge clk) begin
    if (rst) begin
      hs_q.delete();
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) hs_q.push_back(cyc);
      if (out_valid && !ov_prev) begin
        if (exp_q.size() == 0 || hs_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got %h, expected no result", OUT);
        end else begin
          logic [31:0] e;
          int          el;
          int          h;
          e  = exp_q.pop_front();
          el = lat_q.pop_front();
          h  = hs_q.pop_front();
          chk("quotient", OUT, e);
          chk("latency", 32'(cyc - h), 32'(el));
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input int lat, input bit track);
    bit hs;
    int t;
    if (track) begin
      exp_q.push_back(e);
      lat_q.push_back(lat);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    IN1      = a;
    IN2      = b;
    t        = 0;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 200);
    if (!hs) begin
      n_checks++;
      n_errors++;
      $display("FAIL handshake_timeout: got in_ready=0, expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  logic [31:0] va[12] = '{32'h4C000000, 32'h40000000, 32'h40000000, 32'h40000000,
                          32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000001,
                          32'hB4000000, 32'h4C000000, 32'h48000000, 32'h00000000};
  logic [31:0] vb[12] = '{32'h48000000, 32'h38000000, 32'hC0000000, 32'h00000000,
                          32'h40000000, 32'h40000000, 32'h00000001, 32'h7FFFFFFF,
                          32'h48000000, 32'h50000000, 32'h4C000000, 32'h00000000};
  logic [31:0] ve[12] = '{32'h44000000, 32'h48000000, 32'hC0000000, 32'h80000000,
                          32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000001,
                          32'hBC000000, 32'h3C000000, 32'h3AAAAAAB, 32'h80000000};
  int          vl[12] = '{35, 35, 35, 2, 2, 2, 35, 35, 35, 35, 35, 2};

  initial begin
    int t;
    int ce;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    IN1       = '0;
    IN2       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", OUT, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors
    for (int i = 0; i < 12; i++) send(va[i], vb[i], ve[i], vl[i], 1'b1);
    wait_drain();

    // Consumer stall in DONE, then back-to-back acceptance
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h4C000000, 32'h48000000, 32'h44000000, 35, 1'b1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 100);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    IN1      = 32'h40000000;
    IN2      = 32'h38000000;
    exp_q.push_back(32'h48000000);
    lat_q.push_back(35);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out", OUT, 32'h44000000);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    ce = cyc;
    t  = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 10);
    chk("accept_gap", 32'(cyc - ce), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drain();

    // Reset in the middle of DIVIDE discards the operation
    send(32'h40000000, 32'h38000000, 32'h0, 35, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (45) @(posedge clk);
    send(32'h50000000, 32'h48000000, 32'h48000000, 35, 1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/posit_divider_seq.md
Name: posit_divider_seq

Overview:
- Iterative posit divider: OUT = IN1 / IN2 for posits of width N with ES exponent bits.
- Companion of the combinational posit multiplier and the inverse operation in the PPU arithmetic set. Reuses the same decode format (sign, regime k, exponent, hidden-bit mantissa) and the same round-to-nearest-even packing.
- Sequential, with a valid/ready handshake on input and output. Computes one quotient bit per cycle by restoring division.

Parameters:
- N, 32, posit width in bits.
- ES, 2, exponent field width.
- RS, $clog2(N), regime magnitude width; scale registers are RS+ES+2 bits, signed.
- QW, N, quotient bits generated per division (integer bit, fraction, guard).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- IN1  input  N  dividend, posit.
- IN2  input  N  divisor, posit.
- out_valid  output  1  OUT holds a result.
- out_ready  input  1  consumer accepts the result.
- OUT  output  N  quotient, posit.
- busy  output  1  high in every state except IDLE.

Behaviour:
- One clock. Reset is synchronous and active-high. While rst is high at a clk edge: state=IDLE, out_valid=0, OUT=0, busy=0, counter=0. in_ready is 0 while rst is asserted and 1 in IDLE afterwards.
- States: IDLE, DECODE, DIVIDE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid at an edge, register IN1/IN2 and go to DECODE. Operands are sampled only on that handshake edge.
- DECODE (1 cycle):
  - Unpack both operands: two's-complement negatives are negated first, then sign, k, e, and mantissa with hidden bit (left-aligned, F+1 bits, F=N-ES-3).
  - Scale s = k*2^ES + e. Result sign = Sign1 ^ Sign2. Result scale = s1 - s2.
  - Special cases go straight to DONE:
    - IN1 or IN2 is NaR (1 followed by N-1 zeros) → OUT = NaR.
    - IN2 = 0 → OUT = NaR.
    - Otherwise IN1 = 0 → OUT = 0.
  - All other inputs: load remainder = mant1, counter = 0, go to DIVIDE.
- DIVIDE (exactly QW cycles): each cycle, if rem >= mant2 then q bit = 1 and rem -= mant2, else q bit = 0; then rem <<= 1 and counter++. Leave after counter reaches QW-1.
- ROUND (1 cycle):
  - If the quotient MSB is 0 (mant1 < mant2): shift the quotient left by 1 and decrement the scale.
  - sticky = OR of the remaining remainder bits and any truncated quotient bits.
  - Rebuild regime/exponent/fraction. Round to nearest, ties to even.
  - Saturate: |result| never rounds to 0 (gives minpos) and never to NaR (gives maxpos).
  - Negate the packed result if the result sign is 1. Go to DONE.
- DONE: out_valid=1, OUT stable. When out_ready=1 at an edge, return to IDLE and clear out_valid. OUT holds its value until the next result is loaded.
- Latency, from handshake edge to first cycle with out_valid=1:
  - normal operands: QW+3 cycles (35 at defaults);
  - special cases: 2 cycles.
- Back-to-back: no new operand is accepted in DONE (in_ready=0), even when out_ready=1. IDLE always occupies one cycle between results.
- in_valid arriving outside IDLE is ignored; the source must hold it.
- rst during DIVIDE/ROUND/DONE: the operation is discarded and no out_valid appears for it.
- Counter is $clog2(QW+1) bits wide and never wraps within an operation.

Decomposition:
- Package posit_div_pkg:
  - state enum (IDLE, DECODE, DIVIDE, ROUND, DONE);
  - functions nar(N) and maxpos(N);
  - function for the scale-width localparam.
- One sub-module: posit_div_round. It is purely combinational and takes sign, scale, quotient and sticky, and produces the rounded, saturated, packed posit. It is instantiated inside the ROUND stage and can be tested on its own.
- Decode logic stays inline, or reuses the existing extraction unit.

Test Plan:
- IN1=0x4C000000 (3.0), IN2=0x48000000 (2.0) → OUT=0x44000000 (1.5); out_valid first high 35 cycles after the handshake.
- IN1=0x40000000 (1.0), IN2=0x38000000 (0.5) → 0x48000000 (2.0). IN1=0x40000000, IN2=0xC0000000 (-1.0) → 0xC0000000.
- IN2=0x00000000 with IN1=0x40000000 → 0x80000000 at 2 cycles. IN1=0x80000000 → 0x80000000. IN1=0, IN2=0x40000000 → 0x00000000.
- IN1=0x7FFFFFFF (maxpos), IN2=0x00000001 (minpos) → 0x7FFFFFFF. Swapped operands → 0x00000001 (saturation, no zero).
- Hold out_ready=0 for 10 cycles in DONE → OUT and out_valid stable, in_ready=0. Then out_ready=1 → IDLE, and the next operand is accepted one cycle later.
- Assert rst in DIVIDE cycle 5 → the next cycle is IDLE, out_valid=0, busy=0. A following 4.0/2.0 (0x50000000/0x48000000) gives 0x48000000.
